// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the stage sequencer and its decode/ALU/memory neighbours.
interface stage_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             endProgram;
  logic             branch;
  logic             branch_taken;
  logic             memRead;
  logic             memWrite;
  logic             regWrite;
  logic             mem_ready;
  logic [2:0]       stage;
  logic             pc_we;
  logic             pc_sel;
  logic             reg_we;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output start, endProgram, branch, branch_taken, memRead, memWrite, regWrite, mem_ready,
    input  stage, pc_we, pc_sel, reg_we, halted, mem_timeout, cycle_cnt, instr_cnt
  );

  modport slave (
    input  start, endProgram, branch, branch_taken, memRead, memWrite, regWrite, mem_ready,
    output stage, pc_we, pc_sel, reg_we, halted, mem_timeout, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer with memory-wait timeout and cycle/retire counters.
// Optional macro STAGE_SKIP_EN: EXECUTE jumps straight to WRITEBACK for non-memory instructions.
//
// state     | meaning
// FETCH     | 0: instruction fetch, one cycle
// DECODE    | 1: decode, one cycle
// EXECUTE   | 2: ALU; latches control flags, endProgram goes to HALT
// MEMORY    | 3: data memory access, waits for mem_ready up to MEM_TIMEOUT cycles
// WRITEBACK | 4: register write, pc_we strobe, retires instruction
// IDLE      | 5: waiting for start
// HALT      | 7: absorbing, only reset leaves
module stage_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst_n,
  stage_sequencer_if.slave bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_IDLE      = 3'd5,
    S_HALT      = 3'd7
  } state_t;

  state_t            r_state;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_reg_wr;
  logic              r_taken;
  logic [WAIT_W-1:0] r_wait;
  logic              r_pc_we;
  logic              r_pc_sel;
  logic              r_reg_we;
  logic              r_halted;
  logic              r_mem_timeout;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_instr_cnt;
  logic              w_taken;
  logic              w_mem_op;

  assign w_taken  = bus.branch & bus.branch_taken;
  assign w_mem_op = r_mem_rd | r_mem_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_reg_wr      <= 1'b0;
      r_taken       <= 1'b0;
      r_wait        <= '0;
      r_pc_we       <= 1'b0;
      r_pc_sel      <= 1'b0;
      r_reg_we      <= 1'b0;
      r_halted      <= 1'b0;
      r_mem_timeout <= 1'b0;
      r_cycle_cnt   <= '0;
      r_instr_cnt   <= '0;
    end else begin
      r_pc_we  <= 1'b0;
      r_pc_sel <= 1'b0;
      r_reg_we <= 1'b0;
      if (r_state != S_IDLE && r_state != S_HALT)
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      case (r_state)
        S_IDLE:    if (bus.start) r_state <= S_FETCH;
        S_FETCH:   r_state <= S_DECODE;
        S_DECODE:  r_state <= S_EXECUTE;
        S_EXECUTE: begin
          if (bus.endProgram) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_mem_rd <= bus.memRead;
            r_mem_wr <= bus.memWrite;
            r_reg_wr <= bus.regWrite;
            r_taken  <= w_taken;
            r_wait   <= WAIT_W'(MEM_TIMEOUT - 1);
`ifdef STAGE_SKIP_EN
            if (!bus.memRead && !bus.memWrite) begin
              r_state  <= S_WRITEBACK;
              r_pc_we  <= 1'b1;
              r_pc_sel <= w_taken;
              r_reg_we <= bus.regWrite;
            end else begin
              r_state <= S_MEMORY;
            end
`else
            r_state <= S_MEMORY;
`endif
          end
        end
        S_MEMORY: begin
          // Down-counter reaching zero without mem_ready forces the advance.
          if (!w_mem_op || bus.mem_ready || r_wait == '0) begin
            r_state  <= S_WRITEBACK;
            r_pc_we  <= 1'b1;
            r_pc_sel <= r_taken;
            r_reg_we <= r_reg_wr;
            if (w_mem_op && !bus.mem_ready) r_mem_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_WRITEBACK: begin
          r_state     <= S_FETCH;
          r_instr_cnt <= r_instr_cnt + 1'b1;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.stage       = r_state;
  assign bus.pc_we       = r_pc_we;
  assign bus.pc_sel      = r_pc_sel;
  assign bus.reg_we      = r_reg_we;
  assign bus.halted      = r_halted;
  assign bus.mem_timeout = r_mem_timeout;
  assign bus.cycle_cnt   = r_cycle_cnt;
  assign bus.instr_cnt   = r_instr_cnt;
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: stage order, memory wait/timeout, branches, halt, async reset.
module tb_stage_sequencer;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  stage_sequencer_if #(.CNT_W(32)) bus ();

  stage_sequencer #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start        = 1'b0;
    bus.endProgram   = 1'b0;
    bus.branch       = 1'b0;
    bus.branch_taken = 1'b0;
    bus.memRead      = 1'b0;
    bus.memWrite     = 1'b0;
    bus.regWrite     = 1'b0;
    bus.mem_ready    = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_stage"}, 32'(bus.stage), 32'd5);
    check({tag, "_pc_we"}, 32'(bus.pc_we), 32'd0);
    check({tag, "_pc_sel"}, 32'(bus.pc_sel), 32'd0);
    check({tag, "_halted"}, 32'(bus.halted), 32'd0);
    check({tag, "_mem_to"}, 32'(bus.mem_timeout), 32'd0);
    check({tag, "_cycle"}, bus.cycle_cnt, 32'd0);
    check({tag, "_instr"}, bus.instr_cnt, 32'd0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_stage(input string tag, input logic [2:0] want, input int budget);
    int n;
    n = 0;
    while (bus.stage !== want && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.stage === want), 32'd1);
  endtask

  initial begin
    int seq[$];
    int n_mem;
    logic saw_pc_we;
    n_checks = 0;
    n_pass   = 0;
    clear_inputs();
    rst_n = 1'b0;
    #7;
    check_reset_state("por");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_hold", 32'(bus.stage), 32'd5);
    check("idle_cycle", bus.cycle_cnt, 32'd0);

    // R-type instruction
`ifdef STAGE_SKIP_EN
    seq = '{0, 1, 2, 4, 0};
`else
    seq = '{0, 1, 2, 3, 4, 0};
`endif
    bus.regWrite = 1'b1;
    pulse_start();
    foreach (seq[i]) begin
      check($sformatf("rtype_stage%0d", i), 32'(bus.stage), 32'(seq[i]));
      check($sformatf("rtype_pcwe%0d", i), 32'(bus.pc_we), 32'(seq[i] == 4));
      if (seq[i] == 4) begin
        check("rtype_pc_sel", 32'(bus.pc_sel), 32'd0);
        check("rtype_reg_we", 32'(bus.reg_we), 32'd1);
      end
      if (i < seq.size() - 1) tick();
    end
    check("rtype_instr", bus.instr_cnt, 32'd1);
    check("rtype_cycle", bus.cycle_cnt, 32'(seq.size() - 1));

    // Load, mem_ready on 3rd MEMORY cycle; early mem_ready in DECODE ignored
    do_reset();
    bus.memRead  = 1'b1;
    bus.regWrite = 1'b1;
    pulse_start();
    tick();
    check("lw_decode", 32'(bus.stage), 32'd1);
    bus.mem_ready = 1'b1;
    tick();
    check("lw_execute", 32'(bus.stage), 32'd2);
    bus.mem_ready = 1'b0;
    tick();
    check("lw_mem1", 32'(bus.stage), 32'd3);
    tick();
    check("lw_mem2", 32'(bus.stage), 32'd3);
    tick();
    check("lw_mem3", 32'(bus.stage), 32'd3);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check("lw_wb", 32'(bus.stage), 32'd4);
    check("lw_wb_pcwe", 32'(bus.pc_we), 32'd1);
    tick();
    check("lw_fetch", 32'(bus.stage), 32'd0);
    check("lw_cycle", bus.cycle_cnt, 32'd7);
    check("lw_no_to", 32'(bus.mem_timeout), 32'd0);

    // BEQ taken then not taken
    do_reset();
    bus.branch       = 1'b1;
    bus.branch_taken = 1'b1;
    pulse_start();
    wait_stage("beq_t_wait", 3'd4, 10);
    check("beq_t_pcwe", 32'(bus.pc_we), 32'd1);
    check("beq_t_sel", 32'(bus.pc_sel), 32'd1);
    check("beq_t_regwe", 32'(bus.reg_we), 32'd0);
    tick();
    bus.branch_taken = 1'b0;
    wait_stage("beq_n_wait", 3'd4, 10);
    check("beq_n_pcwe", 32'(bus.pc_we), 32'd1);
    check("beq_n_sel", 32'(bus.pc_sel), 32'd0);
    tick();
    check("beq_instr", bus.instr_cnt, 32'd2);

    // endProgram with branch -> HALT
    do_reset();
    bus.endProgram   = 1'b1;
    bus.branch       = 1'b1;
    bus.branch_taken = 1'b1;
    pulse_start();
    tick();
    tick();
    check("halt_exec", 32'(bus.stage), 32'd2);
    tick();
    check("halt_stage", 32'(bus.stage), 32'd7);
    check("halt_flag", 32'(bus.halted), 32'd1);
    check("halt_cycle", bus.cycle_cnt, 32'd3);
    bus.start = 1'b1;
    saw_pc_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.pc_we === 1'b1) saw_pc_we = 1'b1;
    end
    bus.start = 1'b0;
    check("halt_no_pcwe", 32'(saw_pc_we), 32'd0);
    check("halt_stay", 32'(bus.stage), 32'd7);
    check("halt_cyc_frz", bus.cycle_cnt, 32'd3);
    check("halt_ins_frz", bus.instr_cnt, 32'd0);

    // Store timeout, then async reset mid-DECODE
    do_reset();
    bus.memWrite = 1'b1;
    pulse_start();
    tick();
    tick();
    tick();
    n_mem = 0;
    while (bus.stage === 3'd3 && n_mem < 40) begin
      n_mem++;
      tick();
    end
    check("sw_mem_cycles", 32'(n_mem), 32'd15);
    check("sw_wb", 32'(bus.stage), 32'd4);
    check("sw_timeout", 32'(bus.mem_timeout), 32'd1);
    tick();
    tick();
    check("sw_sticky", 32'(bus.mem_timeout), 32'd1);
    check("sw_decode", 32'(bus.stage), 32'd1);
    check("sw_instr", bus.instr_cnt, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("arst");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_idle", 32'(bus.stage), 32'd5);
    check("post_rst_instr", bus.instr_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 CNT_W, 32, width of the cycle and retired-instruction counters.
REQ-002 MEM_TIMEOUT, 15, maximum cycles spent in MEMORY waiting for mem_ready before forced advance.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle pulse that leaves IDLE and begins fetching.
REQ-006 endProgram  input  1  decode halt flag, sampled only in EXECUTE.
REQ-007 branch  input  1  decode branch flag, sampled only in EXECUTE.
REQ-008 branch_taken  input  1  ALU compare result, sampled only in EXECUTE.
REQ-009 memRead, memWrite, regWrite  input  1 each  decode control flags, sampled in EXECUTE and held internally.
REQ-010 mem_ready  input  1  data-memory completion strobe, sampled only in MEMORY.
REQ-011 stage  output  3  current stage code: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, IDLE=5, HALT=7.
REQ-012 pc_we  output  1  one-cycle PC update strobe.
REQ-013 pc_sel  output  1  1 = branch target, 0 = PC+4; valid while pc_we=1.
REQ-014 halted  output  1  high while stage=HALT.
REQ-015 mem_timeout  output  1  sticky flag, set when a MEMORY wait expires.
REQ-016 cycle_cnt  output  CNT_W  cycles elapsed since leaving IDLE.
REQ-017 instr_cnt  output  CNT_W  instructions retired.

Function
REQ-018 stage shall be a registered state; each state lasts at least one clk cycle, so a consumer sampling stage==1 sees exactly one qualifying edge per instruction.
REQ-019 IDLE shall move to FETCH on the cycle after start=1; start in any other state shall be ignored.
REQ-020 FETCH shall go to DECODE, and DECODE to EXECUTE, unconditionally after one cycle.
REQ-021 In EXECUTE, endProgram=1 shall go to HALT and take priority over every other flag; otherwise the next state shall be MEMORY.
REQ-022 In EXECUTE, the block shall latch memRead, memWrite, regWrite and (branch AND branch_taken) into internal registers used by the following states.
REQ-023 In MEMORY with latched memRead or memWrite, the block shall hold until mem_ready=1 and then go to WRITEBACK; otherwise it shall go to WRITEBACK after one cycle.
REQ-024 A MEMORY wait counter shall force the move to WRITEBACK and set mem_timeout after MEM_TIMEOUT cycles without mem_ready.
REQ-025 WRITEBACK shall go to FETCH after one cycle, assert pc_we for exactly that cycle with pc_sel equal to the latched branch-taken value, and increment instr_cnt by one.
REQ-026 HALT shall be absorbing; only rst_n leaves it; pc_we=0; neither counter advances.
REQ-027 cycle_cnt shall increment every cycle outside IDLE and HALT and wrap to 0 modulo 2^CNT_W; instr_cnt shall wrap the same way.
REQ-028 mem_ready when not in MEMORY, and branch flags outside EXECUTE, shall have no effect.

Reset
REQ-029 rst_n low shall immediately force stage=IDLE, pc_we=0, pc_sel=0, halted=0, mem_timeout=0, cycle_cnt=0, instr_cnt=0, and clear all latched flags and the wait counter, regardless of clk.
REQ-030 Reset asserted mid-instruction shall abandon that instruction: no pc_we and no instr_cnt increment for it.
REQ-031 After rst_n deasserts, the block shall stay in IDLE until start.

Configuration
REQ-032 With STAGE_SKIP_EN defined, EXECUTE shall go directly to WRITEBACK when latched memRead=memWrite=0, and WRITEBACK shall still occur for every instruction so that pc_we is issued.
REQ-033 Without STAGE_SKIP_EN, every non-halting instruction shall pass through all five stages: 5 cycles minimum, plus memory wait cycles.

Verification
REQ-034 Reset, then start pulse, R-type flags (regWrite=1) held, mem_ready idle -> stage sequence 5,0,1,2,3,4,0; pc_we=1 only in stage 4 with pc_sel=0; instr_cnt=1 after the first WRITEBACK.
REQ-035 Load (memRead=1), mem_ready asserted on the 3rd MEMORY cycle -> stage=3 for 3 cycles, then 4; cycle_cnt=7 at the return to FETCH.
REQ-036 BEQ with branch=1, branch_taken=1 in EXECUTE -> pc_we=1 and pc_sel=1 in WRITEBACK; repeat with branch_taken=0 -> pc_sel=0.
REQ-037 endProgram=1 together with branch=1 in EXECUTE -> stage=7 and halted=1 next cycle; no pc_we; counters frozen for 20 cycles; start ignored.
REQ-038 Store with mem_ready never asserted -> WRITEBACK after exactly 15 MEMORY cycles and mem_timeout=1; then rst_n pulsed low mid-DECODE -> all outputs at reset values asynchronously.
REQ-039 STAGE_SKIP_EN build, addi (memRead=memWrite=0) -> sequence 0,1,2,4,0 (4 cycles per instruction); lw still visits stage 3.
